// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one solver-RAM port among NUM_REQ requesters
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req/req_wr             per-requester request and write flag (1 = write)
//   req_addr/req_wdata     packed per-requester address [i*AW +: AW] and data [i*DW +: DW]
//   req_lock               burst lock request (only with ARB_BURST_LOCK_EN defined)
//   gnt                    one-hot grant, transaction accepted at this posedge
//   rd_valid/rd_data       one-hot read-return tag and RAM read data, one cycle after a read grant
//   ram_address/ram_data_write/ram_WR_signal/ram_data_read   RAM port pins
// Optional feature macro: ARB_BURST_LOCK_EN (burst locking of the port to one requester).
module ram_port_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 10,
    parameter int NUM_REQ       = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
`ifdef ARB_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]               req_lock,
`endif
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [ADDRESS_WIDTH-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0]            ram_data_write,
    output logic                             ram_WR_signal,
    input  logic [DATA_WIDTH-1:0]            ram_data_read
);
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] ptr, g;
    logic any, act;
    logic [NUM_REQ-1:0] elig;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NUM_REQ);
    endfunction

    // Scanning from the far end lets the nearest eligible requester after ptr win last.
    always_comb begin
        any = 1'b0;
        g = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[wrap(int'(ptr) + k)]) begin
                any = 1'b1;
                g = wrap(int'(ptr) + k);
            end
        end
    end

    assign act = any && rst_n;
    assign gnt = act ? NUM_REQ'(1) << g : '0;
    assign ram_WR_signal = act && req_wr[g];
    assign ram_address = act ? req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    assign ram_data_write = act ? req_wdata[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rd_data = ram_data_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            rd_valid <= '0;
        end else begin
            if (act) ptr <= wrap(int'(g) + 1);
            rd_valid <= (act && !req_wr[g]) ? gnt : '0;
        end
    end

`ifdef ARB_BURST_LOCK_EN
    logic lock_active;
    logic [PW-1:0] lock_owner;

    // ptr needs no special handling: only the owner is granted while locked,
    // so ptr already sits at owner+1 from the locking grant onward.
    assign elig = lock_active ? req & (NUM_REQ'(1) << lock_owner) : req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner <= '0;
        end else if (act) begin
            lock_active <= req_lock[g];
            lock_owner <= g;
        end else if (lock_active && !req_lock[lock_owner] && !req[lock_owner]) begin
            lock_active <= 1'b0;
        end
    end
`else
    assign elig = req;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter against a rule-level reference model
module tb_ram_port_arbiter;
    localparam int N = 3, AW = 10, DW = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req, req_wr, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0] gnt, rd_valid;
    logic [DW-1:0] rd_data, ram_data_write, ram_data_read;
    logic [AW-1:0] ram_address;
    logic ram_WR_signal;
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] m_mem [1024];
    logic [DW-1:0] m_pend_data;
    int m_ptr, m_pend, m_lock;
    int pass_n = 0, total_n = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
`ifdef ARB_BURST_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .ram_address(ram_address),
        .ram_data_write(ram_data_write),
        .ram_WR_signal(ram_WR_signal),
        .ram_data_read(ram_data_read)
    );

    always @(posedge clk) begin
        if (ram_WR_signal) ram[ram_address] <= ram_data_write;
        else ram_data_read <= ram[ram_address];
    end

    function automatic logic [N-1:0] onehot(input int i);
        return (i < 0) ? '0 : N'(1) << i;
    endfunction

    function automatic int exp_g(input logic [N-1:0] r);
        if (m_lock >= 0) return r[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset;
        m_ptr = 0;
        m_pend = -1;
        m_lock = -1;
    endtask

    task automatic clear;
        req = '0;
        req_wr = '0;
        req_lock = '0;
        req_addr = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        req_wr[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic tick(output int g);
        logic [AW-1:0] a;
        g = exp_g(req);
        @(posedge clk);
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            m_ptr = (g + 1) % N;
            m_lock = req_lock[g] ? g : -1;
            if (req_wr[g]) begin
                m_mem[a] = req_wdata[g*DW +: DW];
                m_pend = -1;
            end else begin
                m_pend = g;
                m_pend_data = m_mem[a];
            end
        end else begin
            m_pend = -1;
            if (m_lock >= 0 && !req_lock[m_lock] && !req[m_lock]) m_lock = -1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clear();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 64'hA5);
        rst_n = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            #1;
            total_n++;
            if (gnt !== '0) $display("FAIL reset_gnt got=%b exp=000", gnt); else pass_n++;
            total_n++;
            if (ram_WR_signal !== 1'b0) $display("FAIL reset_wr got=%b exp=0", ram_WR_signal); else pass_n++;
            total_n++;
            if (rd_valid !== '0) $display("FAIL reset_rd_valid got=%b exp=000", rd_valid); else pass_n++;
            total_n++;
            if (ram_address !== '0) $display("FAIL reset_addr got=%h exp=0", ram_address); else pass_n++;
        end
        clear();
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        int g;
        logic [DW-1:0] d;
        clear();
        for (int a = 0; a < 16; a++) begin
            d = {$urandom, $urandom};
            set_req(0, 1'b1, AW'(a), d);
            #1;
            total_n++;
            if (gnt !== 3'b001) $display("FAIL fill_gnt got=%b exp=001", gnt); else pass_n++;
            total_n++;
            if (ram_WR_signal !== 1'b1 || ram_address !== AW'(a) || ram_data_write !== d)
                $display("FAIL fill_pins got=%b/%h/%h exp=1/%h/%h", ram_WR_signal, ram_address, ram_data_write, a, d);
            else pass_n++;
            total_n++;
            if (rd_valid !== '0) $display("FAIL fill_rd_valid got=%b exp=000", rd_valid); else pass_n++;
            tick(g);
        end
        clear();
        tick(g);
    endtask

    task automatic test_round_robin;
        int g;
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k + 4), '0);
            else clear();
            #1;
            total_n++;
            if (gnt !== ((i < 6) ? onehot(i % N) : 3'b000))
                $display("FAIL rr_gnt cycle %0d got=%b exp=%b", i, gnt, (i < 6) ? onehot(i % N) : 3'b000);
            else pass_n++;
            total_n++;
            if (rd_valid !== ((i > 0) ? onehot((i - 1) % N) : 3'b000))
                $display("FAIL rr_rd_valid cycle %0d got=%b exp=%b", i, rd_valid, (i > 0) ? onehot((i - 1) % N) : 3'b000);
            else pass_n++;
            if (i > 0) begin
                total_n++;
                if (rd_data !== m_pend_data) $display("FAIL rr_rd_data cycle %0d got=%h exp=%h", i, rd_data, m_pend_data); else pass_n++;
            end
            tick(g);
        end
    endtask

    task automatic test_write_read;
        int g;
        clear();
        set_req(1, 1'b1, 10'd5, 64'hDEAD);
        #1;
        total_n++;
        if (gnt !== onehot(exp_g(req))) $display("FAIL wr_gnt got=%b exp=%b", gnt, onehot(exp_g(req))); else pass_n++;
        total_n++;
        if (ram_WR_signal !== 1'b1 || ram_address !== 10'd5 || ram_data_write !== 64'hDEAD)
            $display("FAIL wr_pins got=%b/%h/%h exp=1/005/dead", ram_WR_signal, ram_address, ram_data_write);
        else pass_n++;
        tick(g);
        clear();
        set_req(2, 1'b0, 10'd5, '0);
        #1;
        total_n++;
        if (rd_valid !== '0) $display("FAIL wr_no_rd_valid got=%b exp=000", rd_valid); else pass_n++;
        total_n++;
        if (gnt !== 3'b100) $display("FAIL rd_gnt got=%b exp=100", gnt); else pass_n++;
        tick(g);
        clear();
        #1;
        total_n++;
        if (rd_valid !== 3'b100) $display("FAIL rd_valid got=%b exp=100", rd_valid); else pass_n++;
        total_n++;
        if (rd_data !== 64'hDEAD) $display("FAIL rd_data got=%h exp=dead", rd_data); else pass_n++;
        tick(g);
    endtask

    task automatic test_single_req;
        int g;
        clear();
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, AW'(i), '0);
            #1;
            total_n++;
            if (gnt !== 3'b001) $display("FAIL single_gnt cycle %0d got=%b exp=001", i, gnt); else pass_n++;
            if (i > 0) begin
                total_n++;
                if (rd_valid !== 3'b001 || rd_data !== m_mem[i-1])
                    $display("FAIL single_rd cycle %0d got=%b/%h exp=001/%h", i, rd_valid, rd_data, m_mem[i-1]);
                else pass_n++;
            end
            tick(g);
        end
        for (int k = 0; k < N; k++) set_req(k, 1'b0, '0, '0);
        #1;
        total_n++;
        if (gnt !== 3'b010) $display("FAIL single_ptr got=%b exp=010", gnt); else pass_n++;
        tick(g);
        clear();
        tick(g);
    endtask

    task automatic test_reset_mid_read;
        int g;
        clear();
        set_req(0, 1'b0, 10'd2, '0);
        tick(g);
        #1;
        total_n++;
        if (gnt !== 3'b001) $display("FAIL midrst_gnt got=%b exp=001", gnt); else pass_n++;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        total_n++;
        if (gnt !== '0 || ram_WR_signal !== 1'b0) $display("FAIL midrst_gnt_low got=%b/%b exp=000/0", gnt, ram_WR_signal); else pass_n++;
        @(posedge clk);
        @(negedge clk);
        #1;
        total_n++;
        if (rd_valid !== '0) $display("FAIL midrst_rd_valid got=%b exp=000", rd_valid); else pass_n++;
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, '0, '0);
        #1;
        total_n++;
        if (gnt !== 3'b001) $display("FAIL midrst_ptr got=%b exp=001", gnt); else pass_n++;
        tick(g);
        clear();
        tick(g);
    endtask

    task automatic test_idle;
        int g;
        clear();
        tick(g);
        for (int i = 0; i < 5; i++) begin
            #1;
            total_n++;
            if (gnt !== '0 || ram_WR_signal !== 1'b0 || rd_valid !== '0)
                $display("FAIL idle cycle %0d got=%b/%b/%b exp=000/0/000", i, gnt, ram_WR_signal, rd_valid);
            else pass_n++;
            tick(g);
        end
    endtask

`ifdef ARB_BURST_LOCK_EN
    task automatic test_lock;
        int g;
        clear();
        set_req(0, 1'b0, '0, '0);
        tick(g);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), '0);
        for (int i = 0; i < 3; i++) begin
            req_lock[1] = (i < 2);
            #1;
            total_n++;
            if (gnt !== 3'b010) $display("FAIL lock_gnt burst %0d got=%b exp=010", i, gnt); else pass_n++;
            tick(g);
        end
        req[1] = 1'b0;
        req_lock[1] = 1'b0;
        #1;
        total_n++;
        if (gnt !== 3'b100) $display("FAIL lock_release got=%b exp=100", gnt); else pass_n++;
        tick(g);
        clear();
        tick(g);
    endtask
`endif

    task automatic start(input int i);
        set_req(i, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), {$urandom, $urandom});
`ifdef ARB_BURST_LOCK_EN
        req_lock[i] = ($urandom_range(3, 0) == 0);
`endif
    endtask

    task automatic test_random;
        int g, eg;
        clear();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if (!req[i] && $urandom_range(1, 0) == 1) start(i);
            #1;
            eg = exp_g(req);
            total_n++;
            if (gnt !== onehot(eg)) $display("FAIL rand_gnt cycle %0d got=%b exp=%b", c, gnt, onehot(eg)); else pass_n++;
            total_n++;
            if (rd_valid !== onehot(m_pend)) $display("FAIL rand_rd_valid cycle %0d got=%b exp=%b", c, rd_valid, onehot(m_pend)); else pass_n++;
            if (m_pend >= 0) begin
                total_n++;
                if (rd_data !== m_pend_data) $display("FAIL rand_rd_data cycle %0d got=%h exp=%h", c, rd_data, m_pend_data); else pass_n++;
            end
            total_n++;
            if (ram_WR_signal !== (eg >= 0 && req_wr[eg]) || ram_address !== ((eg >= 0) ? req_addr[eg*AW +: AW] : '0))
                $display("FAIL rand_pins cycle %0d got=%b/%h exp=%b/%h", c, ram_WR_signal, ram_address,
                         (eg >= 0 && req_wr[eg]), (eg >= 0) ? req_addr[eg*AW +: AW] : '0);
            else pass_n++;
            tick(g);
            if (g >= 0) begin
                if ($urandom_range(1, 0) == 1) start(g);
                else begin
                    req[g] = 1'b0;
                    req_lock[g] = 1'b0;
                end
            end
        end
        clear();
        tick(g);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_round_robin();
        test_write_read();
        test_single_req();
        test_reset_mid_read();
        test_idle();
`ifdef ARB_BURST_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
